// File: rtl/fetch_stage.sv
// Instruction-fetch stage with a single-outstanding imem request, a one-entry
// skid buffer for decode stalls, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] tgt_pc_s;
  logic [31:0] req_pc_plus4_s;
  logic        new_valid_s;
  logic [31:0] new_instr_s;
  logic [31:0] new_pc4_s;

  assign tgt_pc_s       = {redirect_pc[31:2], 2'b00};
  assign req_pc_plus4_s = req_pc_q + 32'd4;

  // Next-state: fetch sequencing, skid buffer and IF/ID update priority
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;
    new_valid_s  = 1'b0;
    new_instr_s  = NOP_WORD;
    new_pc4_s    = ifid_pc4_q;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d     = tgt_pc_s;
          req_pc_d = tgt_pc_s;
        end else begin
          req_pc_d = pc_q;
        end
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_d = tgt_pc_s;
          if (imem_ready) begin
            req_pc_d = tgt_pc_s;
            state_d  = FETCH;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ready) begin
          pc_d = req_pc_plus4_s;
          if (!stall) begin
            new_valid_s = 1'b1;
            new_instr_s = imem_rdata;
            new_pc4_s   = req_pc_plus4_s;
            req_pc_d    = req_pc_plus4_s;
            state_d     = FETCH;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = req_pc_plus4_s;
            skid_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else begin
          state_d = FETCH;
        end
      end
      DROP: begin
        // The stale response is discarded; only the architectural PC follows redirects
        if (redirect) begin
          pc_d = tgt_pc_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ready) begin
          req_pc_d = pc_d;
          state_d  = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_valid_d = 1'b0;
          pc_d         = tgt_pc_s;
          req_pc_d     = tgt_pc_s;
          state_d      = FETCH;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          new_valid_s  = skid_valid_q;
          new_instr_s  = skid_instr_q;
          new_pc4_s    = skid_pc4_q;
          skid_valid_d = 1'b0;
          req_pc_d     = pc_q;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    imem_req_d = (state_d == FETCH) || (state_d == DROP);

    if (redirect) begin
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end else if (new_valid_s) begin
      ifid_instr_d = new_instr_s;
      ifid_pc4_d   = new_pc4_s;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC, skid buffer and IF/ID registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      imem_req_q   <= 1'b0;
      skid_instr_q <= NOP_WORD;
      skid_pc4_q   <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      imem_req_q   <= imem_req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req          = imem_req_q;
  assign imem_addr         = req_pc_q;
  assign if_id_instruction = ifid_instr_q;
  assign if_id_pc_plus4    = ifid_pc4_q;
  assign if_id_valid       = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, redirect during a
// waited request, redirect+stall, PC wrap and asynchronous reset mid-request.
module tb_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  logic        zw;
  logic        man_ready;
  logic [31:0] man_rdata;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // zw=1: zero-wait memory answering each request with its own address
  assign imem_ready = zw ? imem_req  : man_ready;
  assign imem_rdata = zw ? imem_addr : man_rdata;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                          input logic vld);
    chk({tag, "_instr"}, if_id_instruction, ins);
    chk({tag, "_pc4"},   if_id_pc_plus4,    pc4);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
  endtask

  initial begin
    reset_n     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    zw          = 1'b1;
    man_ready   = 1'b0;
    man_rdata   = 32'h0000_0000;
    repeat (2) @(negedge clock);

    chk("rst_req",  {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk_ifid("rst", 32'h0000_0000, 32'h0000_0000, 1'b0);
    reset_n = 1'b1;

    // Streaming with zero-wait memory
    tick();
    chk("idle_req",  {31'd0, imem_req}, 32'd1);
    chk("idle_addr", imem_addr, 32'h0000_0000);
    chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk_ifid("s0", 32'h0000_0000, 32'h0000_0004, 1'b1);
    tick();
    chk_ifid("s1", 32'h0000_0004, 32'h0000_0008, 1'b1);
    tick();
    chk_ifid("s2", 32'h0000_0008, 32'h0000_000C, 1'b1);
    chk("s2_addr", imem_addr, 32'h0000_000C);

    // Three stall cycles: skid captures 0xC, request drops
    stall = 1'b1;
    tick();
    chk("st1_req", {31'd0, imem_req}, 32'd0);
    chk_ifid("st1", 32'h0000_0008, 32'h0000_000C, 1'b1);
    tick();
    tick();
    chk("st3_req", {31'd0, imem_req}, 32'd0);
    chk_ifid("st3", 32'h0000_0008, 32'h0000_000C, 1'b1);
    stall = 1'b0;
    tick();
    chk_ifid("skid", 32'h0000_000C, 32'h0000_0010, 1'b1);
    chk("skid_req",  {31'd0, imem_req}, 32'd1);
    chk("skid_addr", imem_addr, 32'h0000_0010);
    tick();
    chk_ifid("resume", 32'h0000_0010, 32'h0000_0014, 1'b1);

    // Waited request at 0x14, redirect to 0x100 on first wait cycle
    zw          = 1'b0;
    man_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    chk("drop_req",  {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_0014);
    chk_ifid("flush", 32'h0000_0000, 32'h0000_0014, 1'b0);
    redirect = 1'b0;
    tick();
    chk("drop2_addr", imem_addr, 32'h0000_0014);
    chk("drop2_valid", {31'd0, if_id_valid}, 32'd0);
    man_ready = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    chk("refetch_addr", imem_addr, 32'h0000_0100);
    chk("refetch_req",  {31'd0, imem_req}, 32'd1);
    chk_ifid("discard", 32'h0000_0000, 32'h0000_0014, 1'b0);
    man_ready = 1'b0;
    zw        = 1'b1;
    tick();
    chk_ifid("tgt", 32'h0000_0100, 32'h0000_0104, 1'b1);

    // Redirect and stall together: flush wins
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    chk_ifid("rs_flush", 32'h0000_0000, 32'h0000_0104, 1'b0);
    chk("rs_addr", imem_addr, 32'h0000_0100);
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    chk_ifid("rs_next", 32'h0000_0100, 32'h0000_0104, 1'b1);

    // Unaligned redirect near the top of memory, PC+4 wraps
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_flush", {31'd0, if_id_valid}, 32'd0);
    redirect = 1'b0;
    tick();
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    tick();
    chk_ifid("wrap2", 32'h0000_0000, 32'h0000_0004, 1'b1);

    // Async reset in the middle of a waited request
    zw        = 1'b0;
    man_ready = 1'b0;
    tick();
    chk("wait_addr", imem_addr, 32'h0000_0004);
    chk_ifid("wait", 32'h0000_0000, 32'h0000_0004, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req",  {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0000_0000);
    chk_ifid("arst", 32'h0000_0000, 32'h0000_0000, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    zw      = 1'b1;
    tick();
    chk("rr_req",  {31'd0, imem_req}, 32'd1);
    chk("rr_addr", imem_addr, 32'h0000_0000);
    tick();
    chk_ifid("rr0", 32'h0000_0000, 32'h0000_0004, 1'b1);
    tick();
    chk_ifid("rr1", 32'h0000_0004, 32'h0000_0008, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
